// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and default timing for the push-button reader.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG_HELD
  } btn_state_e;

  localparam int CLK_HZ           = 27_000_000;
  localparam int DEBOUNCE_DEFAULT = CLK_HZ / 100;  // 10 ms
  localparam int LONG_DEFAULT     = CLK_HZ;        // 1 s

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - two-flop synchroniser and debounce counter for an active-low button pin.
module sync_debounce
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic btn_n_raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          btn_s;
  logic [CW-1:0] cnt;

  assign btn_s = ~sync2;

  // The counter only runs while the synchronised pin disagrees with the accepted level.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync1 <= btn_n_raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      fall  <= 1'b0;
      if (btn_s == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= btn_s;
        rise  <= btn_s;
        fall  <= ~btn_s;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/button_reader.sv
// rtl/button_reader.sv - debounced button level, press/release pulses, click classification and press count.
module button_reader
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int LONG_CYCLES     = LONG_DEFAULT
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       btn_n_raw,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_click,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic deb_level;
  logic deb_rise;
  logic deb_fall;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .btn_n_raw(btn_n_raw),
    .level    (deb_level),
    .rise     (deb_rise),
    .fall     (deb_fall)
  );

  btn_state_e    state;
  btn_state_e    state_next;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_next;
  logic [7:0]    count_next;
  logic          press_next;
  logic          release_next;
  logic          short_next;
  logic          long_next;

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_click   <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_next;
      pressed       <= deb_level;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      short_click   <= short_next;
      long_pulse    <= long_next;
      press_count   <= count_next;
    end
  end

  // A release seen on the threshold cycle takes priority, so that press stays a short click.
  always_comb begin
    state_next   = state;
    hold_next    = hold_cnt;
    count_next   = press_count;
    press_next   = 1'b0;
    release_next = 1'b0;
    short_next   = 1'b0;
    long_next    = 1'b0;
    case (state)
      IDLE: begin
        if (deb_rise) begin
          state_next = HELD;
          hold_next  = '0;
          press_next = 1'b1;
          count_next = press_count + 8'd1;
        end
      end
      HELD: begin
        if (deb_fall) begin
          state_next   = IDLE;
          release_next = 1'b1;
          short_next   = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = LONG_HELD;
          long_next  = 1'b1;
          hold_next  = hold_cnt + HW'(1);
        end else begin
          hold_next = hold_cnt + HW'(1);
        end
      end
      LONG_HELD: begin
        if (deb_fall) begin
          state_next   = IDLE;
          release_next = 1'b1;
        end else if (hold_cnt != HOLD_MAX) begin
          hold_next = hold_cnt + HW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_button_reader.sv
// tb/tb_button_reader.sv - scoreboard bench for button_reader with a segment-level reference model.
module tb_button_reader;

  localparam int D = 4;
  localparam int L = 20;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_n_raw = 1'b1;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       short_click;
  logic       long_pulse;
  logic [7:0] press_count;

  always #5 sys_clk = ~sys_clk;

  button_reader #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .btn_n_raw    (btn_n_raw),
    .pressed      (pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .short_click  (short_click),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  int edge_cnt = 0;
  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  // pulses = {press, release, short, long}
  typedef struct {
    int         at;
    logic [3:0] pulses;
    logic [7:0] cnt;
    logic       lvl;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks = 0;
  int  fails = 0;

  bit  seg_lvl[$];
  int  seg_len[$];
  bit  m_deb = 1'b0;
  int  m_cnt = 0;
  int  m_press = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, req, edge_cnt);
    end
  endtask

  task automatic push(input int at, input logic [3:0] p, input logic lvl);
    ev_t e;
    e.at = at;
    e.pulses = p;
    e.cnt = 8'(m_cnt);
    e.lvl = lvl;
    exp_q.push_back(e);
  endtask

  task automatic add(input bit lvl, input int len);
    seg_lvl.push_back(lvl);
    seg_len.push_back(len);
  endtask

  // A segment opposite to the accepted level toggles it only if it lasts D samples;
  // the registered outputs then show the change D+2 edges after the segment starts.
  task automatic model_run(input int start);
    int t;
    int ev;
    t = start;
    for (int i = 0; i < seg_lvl.size(); i++) begin
      if (seg_lvl[i] != m_deb && seg_len[i] >= D) begin
        ev = t + D + 2;
        m_deb = seg_lvl[i];
        if (m_deb) begin
          m_cnt = (m_cnt + 1) % 256;
          m_press = ev;
          push(ev, 4'b1000, 1'b1);
        end else begin
          if (ev > m_press + L) push(m_press + L, 4'b0001, 1'b1);
          push(ev, (ev <= m_press + L) ? 4'b0110 : 4'b0100, 1'b0);
        end
      end
      t += seg_len[i];
    end
  endtask

  task automatic run_segs();
    model_run(edge_cnt);
    for (int i = 0; i < seg_lvl.size(); i++) begin
      btn_n_raw = ~seg_lvl[i];
      repeat (seg_len[i]) @(negedge sys_clk);
    end
    seg_lvl.delete();
    seg_len.delete();
  endtask

  always @(posedge sys_clk) begin
    #1;
    if (press_pulse | release_pulse | short_click | long_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", int'({press_pulse, release_pulse, short_click, long_pulse}), 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_edge", edge_cnt - 1, mon_e.at);
        check("event_pulses", int'({press_pulse, release_pulse, short_click, long_pulse}),
              int'(mon_e.pulses));
        check("event_count", int'(press_count), int'(mon_e.cnt));
        check("event_pressed", int'(pressed), int'(mon_e.lvl));
      end
    end
  end

  initial begin
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;

    repeat (50) @(negedge sys_clk);
    check("idle_pressed", int'(pressed), 0);
    check("idle_pulses", int'({press_pulse, release_pulse, short_click, long_pulse}), 0);
    check("idle_count", int'(press_count), 0);

    add(1, 10); add(0, 30);
    run_segs();
    check("click_count", int'(press_count), 1);

    add(1, 3); add(0, 2); add(1, 3); add(0, 30);
    run_segs();
    check("bounce_count", int'(press_count), 1);
    check("bounce_pressed", int'(pressed), 0);

    add(1, 40); add(0, 30);
    run_segs();

    for (int h = L - 1; h <= L + 1; h++) begin
      add(1, h); add(0, 30);
    end
    run_segs();

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) add(i % 2 == 0, $urandom_range(15, 35));
      else add(i % 2 == 0, $urandom_range(1, 8));
    end
    add(0, 40);
    run_segs();
    check("random_count", int'(press_count), m_cnt);

    add(1, 10);
    run_segs();
    rst_n = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    m_deb = 1'b0;
    m_cnt = 0;
    m_press = 0;
    check("reset_queue", exp_q.size(), 0);
    check("reset_pressed", int'(pressed), 0);
    check("reset_count", int'(press_count), 0);
    check("reset_pulses", int'({press_pulse, release_pulse, short_click, long_pulse}), 0);

    add(1, 12); add(0, 6);
    for (int k = 0; k < 256; k++) begin
      add(1, $urandom_range(D, 10));
      add(0, (k == 255) ? 40 : $urandom_range(D, 10));
    end
    run_segs();
    check("wrap_count", int'(press_count), 1);

    repeat (5) @(negedge sys_clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/button_reader.md
Name: button_reader

Overview:
- Input-side counterpart to the LED output blocks: reads one active-low on-board push button and turns it into clean, single-cycle events for the rest of the design.
- Synchronises and debounces the raw pin, tracks a debounced level, and counts presses.
- Classifies each press as a short click or a long press; downstream LED pattern logic consumes the pulses.

Parameters:
- DEBOUNCE_CYCLES, 270_000, consecutive stable cycles needed to accept a level change (10 ms at 27 MHz); legal range ≥1.
- LONG_CYCLES, 27_000_000, cycles from press_pulse at which a held press becomes long (1 s at 27 MHz); legal range ≥2.

Ports:
- sys_clk  input  1  system clock; the block has exactly one clock.
- rst_n  input  1  reset; synchronous, active-low.
- btn_n_raw  input  1  raw button pin; 0 = pressed; asynchronous, bouncy.
- pressed  output  1  debounced level; 1 = held.
- press_pulse  output  1  one-cycle pulse on debounced press.
- release_pulse  output  1  one-cycle pulse on debounced release.
- short_click  output  1  one-cycle pulse, coincident with release_pulse, when the press never became long.
- long_pulse  output  1  one-cycle pulse when a held press reaches LONG_CYCLES.
- press_count  output  8  count of debounced presses; wraps 255→0.

Behaviour:
- Reset (rst_n sampled 0 at a sys_clk edge):
  - Both synchroniser flops load 1 (released).
  - Debounce counter and hold counter load 0.
  - FSM goes to IDLE.
  - All outputs 0; press_count 0.
  - Reset mid-press discards the press. If the button is still held after reset, it is re-detected with full latency.
- Synchroniser: two flops on btn_n_raw. btn_s = inverted output of the second flop (1 = pressed).
- Debounce:
  - While btn_s equals pressed, the debounce counter is held at 0.
  - While they differ, the counter increments each cycle.
  - When btn_s has differed for DEBOUNCE_CYCLES consecutive cycles, pressed toggles on that edge and the counter clears.
  - Any return of btn_s to equality before then clears the counter. A bounce shorter than DEBOUNCE_CYCLES produces no event.
- Latency: with btn_n_raw first sampled low at edge 0 and held low, pressed and press_pulse rise at edge 2+DEBOUNCE_CYCLES. Release latency is identical.
- FSM states: IDLE, HELD, LONG_HELD. All outputs are registered.
  - IDLE → HELD on debounced press. Same edge: press_pulse=1, press_count+1, hold counter ← 0.
  - HELD: hold counter increments each cycle.
    - When it reaches LONG_CYCLES-1: long_pulse=1 on the next edge, → LONG_HELD. long_pulse is thus LONG_CYCLES cycles after press_pulse.
    - On debounced release: release_pulse=1, short_click=1, → IDLE.
  - LONG_HELD: hold counter saturates (no wrap). On debounced release: release_pulse=1, short_click=0, → IDLE.
- Simultaneous release and long threshold in HELD: release wins. short_click=1, long_pulse never asserted, → IDLE.
- Pulses last exactly one cycle. press_pulse and release_pulse never coincide, since pressed changes at most once per DEBOUNCE_CYCLES.
- Counter widths: debounce counter $clog2(DEBOUNCE_CYCLES+1); hold counter $clog2(LONG_CYCLES+1). No truncation warnings permitted.
- press_count is 8-bit unsigned and wraps silently.

Decomposition:
- Package button_pkg holds:
  - state enum btn_state_e {IDLE, HELD, LONG_HELD};
  - default constants CLK_HZ=27_000_000, DEBOUNCE_DEFAULT, LONG_DEFAULT.
- Sub-module sync_debounce: synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES. Outputs the debounced level and one-cycle rise/fall strobes.
- button_reader instantiates sync_debounce and holds the FSM, hold counter and press_count.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20):
1. Reset, then btn_n_raw=1 for 50 cycles → all outputs 0, press_count=0.
2. btn_n_raw low from edge 0 for 10 cycles, then high → press_pulse at edge 6; release_pulse and short_click together 4 cycles after release is first synchronised; press_count=1; long_pulse never.
3. Bounce: low 3 cycles, high 2, low 3, high → no pulses; pressed stays 0.
4. Hold low 40 cycles → long_pulse exactly 20 cycles after press_pulse. On release: release_pulse=1, short_click=0, FSM IDLE.
5. Release timed so the debounced release lands on the threshold edge → release_pulse=1, short_click=1, long_pulse=0.
6. rst_n=0 for 1 cycle while held, then 256 further clean presses → outputs cleared at reset; held button re-detected after 6 cycles; press_count wraps to 1 after 257 total presses counted since reset.
